// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction-memory read, control-unit handshake, branch redirect
// master is the fetch unit; slave is the memory/control-unit side.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   fetch_req;
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ack;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [3:0]             opcode;
  logic [INSTR_WIDTH-5:0] operand;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   branch_en;
  logic [ADDR_WIDTH-1:0]  branch_target;

  modport master (
    input  fetch_req, imem_rdata, imem_ack, instr_ready, branch_en, branch_target,
    output imem_req, imem_addr, instr_valid, opcode, operand, pc
  );

  modport slave (
    output fetch_req, imem_rdata, imem_ack, instr_ready, branch_en, branch_target,
    input  imem_req, imem_addr, instr_valid, opcode, operand, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pc, imem read, instruction register, branch redirect
// A branch seen while a read is outstanding is parked until the ack, whose data is then dropped.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   redir_q, redir_d;
  logic [ADDR_WIDTH-1:0]  tgt_q, tgt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      redir_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    redir_d = redir_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.branch_en) begin
          pc_d = bus.branch_target;
        end else if (bus.fetch_req) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.imem_ack) begin
          // A redirect in the ack cycle itself beats any parked target.
          if (redir_q || bus.branch_en) begin
            pc_d    = bus.branch_en ? bus.branch_target : tgt_q;
            redir_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            ir_d    = bus.imem_rdata;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = ST_VALID;
          end
        end else if (bus.branch_en) begin
          redir_d = 1'b1;
          tgt_d   = bus.branch_target;
        end
      end
      ST_VALID: begin
        if (bus.branch_en) begin
          pc_d = bus.branch_target;
        end
        if (bus.instr_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == ST_REQ);
    bus.instr_valid = (state_q == ST_VALID);
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.opcode    = ir_q[INSTR_WIDTH-1 -: 4];
  assign bus.operand   = ir_q[INSTR_WIDTH-5:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the processor core. It sits directly upstream of the control unit: it holds the program counter, issues read requests to instruction memory, latches the returned word into an instruction register, and presents the 4-bit opcode plus operand field to the control unit through a valid/ready handshake. It also accepts branch redirects, including one that arrives while a memory read is outstanding.

## Interface

- ADDR_WIDTH, 8, program counter and instruction-memory address width
- INSTR_WIDTH, 16, instruction word width; must be at least 5
- RESET_PC, 0, program counter value after reset

- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  control unit requests the next instruction (level)
- imem_req  out  1  read request to instruction memory
- imem_addr  out  ADDR_WIDTH  read address; always equals pc
- imem_rdata  in  INSTR_WIDTH  read data; valid only when imem_ack=1
- imem_ack  in  1  memory completion strobe, one cycle per request
- instr_valid  out  1  instruction register holds an unconsumed instruction
- instr_ready  in  1  control unit consumes the instruction
- opcode  out  4  IR[INSTR_WIDTH-1 -: 4], the `instruction` input of the control unit
- operand  out  INSTR_WIDTH-4  IR[INSTR_WIDTH-5:0]
- pc  out  ADDR_WIDTH  current program counter
- branch_en  in  1  redirect strobe, one cycle
- branch_target  in  ADDR_WIDTH  redirect address, sampled with branch_en

## Operation

- The FSM has three states:
  - IDLE: no request in flight and no instruction held.
  - REQ: imem_req=1 and the read is outstanding.
  - VALID: instr_valid=1 and the instruction register (IR) holds an instruction.
- Outputs decode from state: imem_req=(REQ), instr_valid=(VALID). imem_addr is pc.
- IDLE transitions:
  - branch_en=1: pc<=branch_target; stay in IDLE. Branch has priority over fetch_req; the fetch starts on the next cycle.
  - Otherwise, fetch_req=1: go to REQ.
- REQ transitions:
  - imem_ack=1 and no redirect pending: IR<=imem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_WIDTH), go to VALID.
  - branch_en=1 without ack: set the redirect_pending flag and hold the target in a register; a later branch_en overwrites the target. imem_req and imem_addr stay stable until the ack.
  - imem_ack=1 with redirect_pending or branch_en set that cycle: discard imem_rdata, leave IR unchanged, pc<=the latest target (branch_en in the same cycle wins), clear the flag, go to IDLE.
- VALID transitions:
  - instr_ready=1: go to IDLE.
  - branch_en=1: pc<=branch_target, whether or not instr_ready is set that cycle.
  - instr_ready=0: IR, opcode and operand hold steady.
  - fetch_req has no effect in VALID.
- imem_ack outside REQ is ignored.
- pc changes only on an accepted ack or on a branch.

## Timing

- Reset (asynchronous, while reset=0):
  - State goes to IDLE, so imem_req=0 and instr_valid=0 immediately.
  - pc=RESET_PC, IR=0, so opcode=0 and operand=0.
  - redirect_pending=0.
- Reset during REQ drops imem_req without waiting for the ack. Any stale ack after reset is ignored because the state is IDLE.
- Minimum latency: fetch_req sampled in IDLE at edge N gives imem_req=1 from N. An ack sampled at edge N+1 gives instr_valid=1 and the new opcode from N+1. That is one cycle of request plus one cycle to valid.
- Each extra wait cycle before imem_ack adds one cycle.
- Back-to-back fetches: consume at edge M, IDLE after M, REQ after M+1. The pipeline bubble between instructions is one cycle minimum.
- opcode and operand change only on an accepted ack edge.

## Test plan

- Reset and simple fetch:
  - Stimulus: RESET_PC=0, memory word 0 = 16'h3A5C, ack one cycle after req, fetch_req held high.
  - Required response: imem_addr=0 and imem_req pulses for one cycle; then instr_valid=1, opcode=4'h3, operand=12'hA5C, pc=1.
  - After instr_ready, the next request is at address 1.
- Stall on both sides:
  - Stimulus: ack delayed 3 cycles, then instr_ready held low for 4 cycles.
  - Required response: imem_req and imem_addr stable for all 4 REQ cycles; opcode and operand stable for all 4 VALID cycles; no second request is issued.
- PC wrap:
  - Stimulus: RESET_PC=8'hFF, one fetch.
  - Required response: address 8'hFF is read, then pc=8'h00.
- Branch during an outstanding read:
  - Stimulus: branch_en with target 8'h40 one cycle after imem_req rises; ack 2 cycles later with data 16'hFFFF.
  - Required response: instr_valid stays 0 and IR is unchanged; pc=8'h40 and the state returns to IDLE.
  - The next request is at 8'h40.
- Simultaneous events:
  - Stimulus: in VALID, branch_en(8'h10) and instr_ready together; separately, branch_en(8'h20) in IDLE together with fetch_req.
  - Required response: the first case reaches IDLE with pc=8'h10. In the second case imem_req rises one cycle later with addr 8'h20.
- Reset mid-operation:
  - Stimulus: assert reset low during REQ, then release; an ack arrives after release with no fetch_req.
  - Required response: imem_req=0 immediately; pc=RESET_PC; the ack is ignored and instr_valid stays 0.
